// File: rtl/preemptive_traffic_controller_if.sv
// Emergency-request port of the traffic controller: the decoder drives a road
// number with valid; the controller answers with ready and a bad-road pulse.
interface preemptive_traffic_controller_if #(
  parameter int NUM_ROADS = 4
);
  localparam int RW = $clog2(NUM_ROADS);

  logic          req_valid;
  logic [RW-1:0] req_road;
  logic          req_ready;
  logic          req_err;

  modport master (output req_valid, req_road, input  req_ready, req_err);
  modport slave  (input  req_valid, req_road, output req_ready, req_err);
endinterface

// File: rtl/preemptive_traffic_controller.sv
// N-road traffic light sequencer with timed green/yellow/all-red phases and
// emergency preemption: save the interrupted road, serve the emergency road, resume.
module preemptive_traffic_controller #(
  parameter int NUM_ROADS     = 4,
  parameter int GREEN_CYCLES  = 8,
  parameter int YELLOW_CYCLES = 2,
  parameter int ALLRED_CYCLES = 1,
  parameter int EMERG_CYCLES  = 6,
  parameter int CNT_W         = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  preemptive_traffic_controller_if.slave req,
  output logic [NUM_ROADS-1:0]          green,
  output logic [NUM_ROADS-1:0]          yellow,
  output logic                          emerg_active,
  output logic [15:0]                   preempt_count
);
  localparam int RW = $clog2(NUM_ROADS);
  localparam logic [RW-1:0]    LAST_ROAD = RW'(NUM_ROADS - 1);
  localparam logic [RW:0]      NR        = (RW+1)'(NUM_ROADS);
  localparam logic [CNT_W-1:0] T_GREEN   = CNT_W'(GREEN_CYCLES);
  localparam logic [CNT_W-1:0] T_YELLOW  = CNT_W'(YELLOW_CYCLES);
  localparam logic [CNT_W-1:0] T_ALLRED  = CNT_W'(ALLRED_CYCLES);
  localparam logic [CNT_W-1:0] T_EMERG   = CNT_W'(EMERG_CYCLES);

  typedef enum logic [2:0] {
    N_GREEN, N_YELLOW, N_ALLRED, E_CLEAR, E_ALLRED, E_GREEN, E_RECOVER, E_ALLRED2
  } state_t;

  state_t           state;
  logic [RW-1:0]    cur_road, saved_road, emerg_road, nxt_road;
  logic [CNT_W-1:0] timer;
  logic             accept, req_bad, expire;

  function automatic logic [NUM_ROADS-1:0] onehot(input logic [RW-1:0] r);
    onehot = NUM_ROADS'(1) << r;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    sat_inc = (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  always_comb begin
    accept   = req.req_valid & req.req_ready;
    req_bad  = {1'b0, req.req_road} >= NR;
    expire   = (timer == CNT_W'(1));
    nxt_road = (cur_road == LAST_ROAD) ? '0 : cur_road + RW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= N_GREEN;
      cur_road      <= '0;
      saved_road    <= '0;
      emerg_road    <= '0;
      timer         <= T_GREEN;
      green         <= onehot(RW'(0));
      yellow        <= '0;
      req.req_ready <= 1'b1;
      req.req_err   <= 1'b0;
      emerg_active  <= 1'b0;
      preempt_count <= '0;
    end else begin
      timer       <= timer - CNT_W'(1);
      req.req_err <= accept & req_bad;
      if (accept && !req_bad) begin
        saved_road    <= cur_road;
        emerg_road    <= req.req_road;
        emerg_active  <= 1'b1;
        req.req_ready <= 1'b0;
        // Preemption wins over a same-cycle timer expiry; partly served
        // clearance phases continue with their remaining time.
        case (state)
          N_GREEN:
            if (req.req_road == cur_road) begin
              state <= E_GREEN;
              timer <= T_EMERG;
            end else begin
              state  <= E_CLEAR;
              timer  <= T_YELLOW;
              green  <= '0;
              yellow <= onehot(cur_road);
            end
          N_YELLOW:
            if (!expire) begin
              state <= E_CLEAR;
            end else begin
              state  <= E_ALLRED;
              timer  <= T_ALLRED;
              yellow <= '0;
            end
          default:
            if (!expire) begin
              state <= E_ALLRED;
            end else begin
              state <= E_GREEN;
              timer <= T_EMERG;
              green <= onehot(req.req_road);
            end
        endcase
      end else if (expire) begin
        case (state)
          N_GREEN: begin
            state  <= N_YELLOW;
            timer  <= T_YELLOW;
            green  <= '0;
            yellow <= onehot(cur_road);
          end
          N_YELLOW: begin
            state    <= N_ALLRED;
            timer    <= T_ALLRED;
            yellow   <= '0;
            cur_road <= nxt_road;
          end
          N_ALLRED: begin
            state <= N_GREEN;
            timer <= T_GREEN;
            green <= onehot(cur_road);
          end
          E_CLEAR: begin
            state  <= E_ALLRED;
            timer  <= T_ALLRED;
            yellow <= '0;
          end
          E_ALLRED: begin
            state <= E_GREEN;
            timer <= T_EMERG;
            green <= onehot(emerg_road);
          end
          E_GREEN: begin
            state  <= E_RECOVER;
            timer  <= T_YELLOW;
            green  <= '0;
            yellow <= onehot(emerg_road);
          end
          E_RECOVER: begin
            state  <= E_ALLRED2;
            timer  <= T_ALLRED;
            yellow <= '0;
          end
          E_ALLRED2: begin
            state         <= N_GREEN;
            timer         <= T_GREEN;
            green         <= onehot(saved_road);
            cur_road      <= saved_road;
            emerg_active  <= 1'b0;
            preempt_count <= sat_inc(preempt_count);
            req.req_ready <= 1'b1;
          end
          default: begin
            state         <= N_GREEN;
            cur_road      <= '0;
            timer         <= T_GREEN;
            green         <= onehot(RW'(0));
            yellow        <= '0;
            req.req_ready <= 1'b1;
            emerg_active  <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_preemptive_traffic_controller.sv
// Bench for preemptive_traffic_controller: directed preemption scenarios with a
// lamp-phase scoreboard (expected phases queued by stimulus, popped by a monitor).
`timescale 1ns/1ps
module tb_preemptive_traffic_controller;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n  = 1'b0;
  logic        reset3_n = 1'b0;
  logic [3:0]  green, yellow;
  logic        emerg_active;
  logic [15:0] preempt_count;
  logic [2:0]  green3, yellow3;
  logic        emerg3;
  logic [15:0] count3;

  preemptive_traffic_controller_if #(.NUM_ROADS(4)) rq ();
  preemptive_traffic_controller_if #(.NUM_ROADS(3)) rq3 ();

  preemptive_traffic_controller #(.NUM_ROADS(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .req(rq),
    .green(green), .yellow(yellow),
    .emerg_active(emerg_active), .preempt_count(preempt_count)
  );

  preemptive_traffic_controller #(.NUM_ROADS(3)) u_dut3 (
    .clk(clk), .reset_n(reset3_n), .req(rq3),
    .green(green3), .yellow(yellow3),
    .emerg_active(emerg3), .preempt_count(count3)
  );

  typedef struct {
    logic [3:0] g;
    logic [3:0] y;
    int         len;
  } phase_t;

  phase_t sb[$];
  int     total = 0;
  int     bad   = 0;
  bit     mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] g, input logic [3:0] y, input int len);
    phase_t p;
    p.g = g; p.y = y; p.len = len;
    sb.push_back(p);
  endtask

  // Monitor: measure each lamp phase and compare it to the next queued one.
  logic [7:0] prev;
  int         run;
  bit         have_prev;
  always @(negedge clk) begin
    if (!mon_en) begin
      have_prev = 1'b0;
      run       = 0;
    end else begin
      check("lamp_exclusive", 32'($countones({green, yellow}) <= 1), 32'd1);
      if (have_prev && ({green, yellow} != prev)) begin
        if (sb.size() != 0) begin
          phase_t e;
          e = sb.pop_front();
          check("phase_lamps", 32'(prev), 32'({e.g, e.y}));
          check("phase_len", 32'(run), 32'(e.len));
        end
        run = 1;
      end else begin
        run = run + 1;
      end
      prev      = {green, yellow};
      have_prev = 1'b1;
    end
  end

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    mon_en       = 1'b0;
    reset_n      = 1'b0;
    rq.req_valid = 1'b0;
    rq.req_road  = '0;
    repeat (2) tick();
    check("rst_green", 32'(green), 32'h1);
    check("rst_yellow", 32'(yellow), 32'h0);
    check("rst_ready", 32'(rq.req_ready), 32'h1);
    check("rst_err", 32'(rq.req_err), 32'h0);
    check("rst_emerg", 32'(emerg_active), 32'h0);
    check("rst_count", 32'(preempt_count), 32'h0);
    reset_n = 1'b1;
    mon_en  = 1'b1;
  endtask

  task automatic request(input logic [1:0] road, input int at_cycle);
    repeat (at_cycle - 1) tick();
    rq.req_valid = 1'b1;
    rq.req_road  = road;
    tick();
    rq.req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rq.req_valid  = 1'b0;
    rq.req_road   = '0;
    rq3.req_valid = 1'b0;
    rq3.req_road  = '0;

    // Normal rotation with wrap from road3 back to road0.
    do_reset();
    for (int r = 0; r < 4; r++) begin
      push(4'(1 << r), 4'h0, 8);
      push(4'h0, 4'(1 << r), 2);
      push(4'h0, 4'h0, 1);
    end
    push(4'h1, 4'h0, 8);
    drain(100);
    check("t1_count", 32'(preempt_count), 32'd0);

    // Preempt road0 green for road2, then resume road0.
    do_reset();
    push(4'h1, 4'h0, 3); push(4'h0, 4'h1, 2); push(4'h0, 4'h0, 1);
    push(4'h4, 4'h0, 6); push(4'h0, 4'h4, 2); push(4'h0, 4'h0, 1);
    push(4'h1, 4'h0, 8);
    request(2'd2, 3);
    check("t2_emerg_on", 32'(emerg_active), 32'd1);
    check("t2_ready_off", 32'(rq.req_ready), 32'd0);
    drain(60);
    check("t2_count", 32'(preempt_count), 32'd1);
    check("t2_emerg_off", 32'(emerg_active), 32'd0);
    check("t2_ready_back", 32'(rq.req_ready), 32'd1);

    // Emergency on the road already green: green extends with no gap.
    do_reset();
    push(4'h1, 4'h0, 8); push(4'h0, 4'h1, 2); push(4'h0, 4'h0, 1);
    push(4'h2, 4'h0, 10); push(4'h0, 4'h2, 2); push(4'h0, 4'h0, 1);
    push(4'h2, 4'h0, 8);
    request(2'd1, 15);
    check("t3_green_kept", 32'(green), 32'h2);
    check("t3_emerg_on", 32'(emerg_active), 32'd1);
    drain(80);
    check("t3_count", 32'(preempt_count), 32'd1);

    // Second request held through the first emergency; both get served.
    do_reset();
    push(4'h1, 4'h0, 3); push(4'h0, 4'h1, 2); push(4'h0, 4'h0, 1);
    push(4'h4, 4'h0, 6); push(4'h0, 4'h4, 2); push(4'h0, 4'h0, 1);
    push(4'h1, 4'h0, 1); push(4'h0, 4'h1, 2); push(4'h0, 4'h0, 1);
    push(4'h8, 4'h0, 6); push(4'h0, 4'h8, 2); push(4'h0, 4'h0, 1);
    push(4'h1, 4'h0, 8);
    request(2'd2, 3);
    rq.req_valid = 1'b1;
    rq.req_road  = 2'd3;
    n = 0;
    while (!rq.req_ready && n < 40) begin
      tick();
      n++;
    end
    check("t5_ready_wait", 32'(n), 32'd12);
    tick();
    rq.req_valid = 1'b0;
    check("t5_second_taken", 32'(rq.req_ready), 32'd0);
    drain(80);
    check("t5_count", 32'(preempt_count), 32'd2);

    // Asynchronous reset in the middle of an emergency green.
    do_reset();
    push(4'h1, 4'h0, 3); push(4'h0, 4'h1, 2); push(4'h0, 4'h0, 1);
    request(2'd2, 3);
    repeat (5) tick();
    #2;
    check("t6_in_egreen", 32'(green), 32'h4);
    check("t6_emerg_before", 32'(emerg_active), 32'd1);
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    check("t6_async_green", 32'(green), 32'h1);
    check("t6_async_emerg", 32'(emerg_active), 32'd0);
    check("t6_async_ready", 32'(rq.req_ready), 32'd1);
    check("t6_prefix_seen", 32'(sb.size()), 32'd0);
    tick();
    reset_n = 1'b1;
    mon_en  = 1'b1;
    push(4'h1, 4'h0, 8); push(4'h0, 4'h1, 2); push(4'h0, 4'h0, 1);
    push(4'h2, 4'h0, 8);
    drain(60);
    check("t6_count", 32'(preempt_count), 32'd0);
    mon_en = 1'b0;

    // Three-road instance: out-of-range road gives a one-cycle error only.
    reset3_n = 1'b0;
    repeat (2) tick();
    reset3_n = 1'b1;
    repeat (2) tick();
    rq3.req_valid = 1'b1;
    rq3.req_road  = 2'd3;
    tick();
    rq3.req_valid = 1'b0;
    check("t4_err_pulse", 32'(rq3.req_err), 32'd1);
    check("t4_emerg", 32'(emerg3), 32'd0);
    check("t4_ready", 32'(rq3.req_ready), 32'd1);
    check("t4_green_kept", 32'(green3), 32'h1);
    tick();
    check("t4_err_clear", 32'(rq3.req_err), 32'd0);
    repeat (3) tick();
    check("t4_green_end", 32'(green3), 32'h1);
    tick();
    check("t4_yellow", 32'(yellow3), 32'h1);
    check("t4_green_off", 32'(green3), 32'h0);
    check("t4_count", 32'(count3), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
